// File: rtl/score_bcd_converter_pkg.sv
// Shared constants and state encoding for the score-to-BCD display path.
package score_bcd_converter_pkg;

  localparam int SCORE_WIDTH = 20;
  localparam int DIGITS      = 6;

  // Largest value representable in 'digits' decimal digits (10^digits - 1),
  // built by repeated multiplication so no division is ever involved.
  function automatic logic [63:0] calc_score_max(input int digits);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < digits; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

  localparam logic [63:0] SCORE_MAX = calc_score_max(DIGITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

endpackage

// File: rtl/score_bcd_converter_digit_adjust.sv
// Double-dabble correction cell: adds 3 to a BCD nibble of 5 or more so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adjust (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  // 4-bit compare-and-add
  always_comb begin
    digit_out = digit_in;
    if (digit_in >= 4'd5) begin
      digit_out = digit_in + 4'd3;
    end
  end

endmodule

// File: rtl/score_bcd_converter.sv
// Sequential double-dabble converter: binary score in, packed BCD digits out.
// One shift per clock; a one-deep pending slot keeps the newest request that
// arrives while a conversion is running.
module score_bcd_converter #(
  parameter int SCORE_WIDTH = score_bcd_converter_pkg::SCORE_WIDTH,
  parameter int DIGITS      = score_bcd_converter_pkg::DIGITS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SCORE_WIDTH-1:0]  score_in,
  input  logic                    score_valid,
  output logic                    busy,
  output logic [4*DIGITS-1:0]     digits_out,
  output logic                    digits_valid,
  output logic                    overflow
);

  import score_bcd_converter_pkg::*;

  localparam logic [63:0] SCORE_MAX_VAL = calc_score_max(DIGITS);
  localparam int          CNT_W         = $clog2(SCORE_WIDTH + 1);
  localparam int          BCD_W         = 4 * DIGITS;

  conv_state_t            state_q, state_d;
  logic                   busy_q, busy_d;
  logic [SCORE_WIDTH-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]       bcd_q, bcd_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ovf_conv_q, ovf_conv_d;
  logic [BCD_W-1:0]       digits_out_q, digits_out_d;
  logic                   overflow_q, overflow_d;
  logic                   digits_valid_q, digits_valid_d;
  logic                   pend_valid_q, pend_valid_d;
  logic [SCORE_WIDTH-1:0] pend_score_q, pend_score_d;

  logic [BCD_W-1:0]       bcd_adj;
  logic                   load_req;
  logic [SCORE_WIDTH-1:0] load_score;
  logic [63:0]            load_ext;
  logic                   load_over;
  logic [SCORE_WIDTH-1:0] load_clamped;

  // One add-3 cell per BCD digit
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_in  (bcd_q[4*gi +: 4]),
      .digit_out (bcd_adj[4*gi +: 4])
    );
  end

  // Request selection and clamping: a fresh score_valid beats the pending slot
  always_comb begin
    load_req     = score_valid | pend_valid_q;
    load_score   = score_valid ? score_in : pend_score_q;
    load_ext     = 64'(load_score);
    load_over    = (load_ext > SCORE_MAX_VAL);
    load_clamped = load_over ? SCORE_MAX_VAL[SCORE_WIDTH-1:0] : load_score;
  end

  // Next-state and datapath logic for the IDLE/SHIFT/DONE sequencer
  always_comb begin
    state_d        = state_q;
    bin_d          = bin_q;
    bcd_d          = bcd_q;
    cnt_d          = cnt_q;
    ovf_conv_d     = ovf_conv_q;
    digits_out_d   = digits_out_q;
    overflow_d     = overflow_q;
    digits_valid_d = 1'b0;
    pend_valid_d   = pend_valid_q;
    pend_score_d   = pend_score_q;

    case (state_q)
      IDLE: begin
        if (load_req) begin
          state_d      = SHIFT;
          bin_d        = load_clamped;
          bcd_d        = '0;
          cnt_d        = '0;
          ovf_conv_d   = load_over;
          pend_valid_d = 1'b0;
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_W'(SCORE_WIDTH)) begin
          state_d        = DONE;
          digits_out_d   = bcd_q;
          overflow_d     = ovf_conv_q;
          digits_valid_d = 1'b1;
        end else begin
          bcd_d = {bcd_adj[BCD_W-2:0], bin_q[SCORE_WIDTH-1]};
          bin_d = {bin_q[SCORE_WIDTH-2:0], 1'b0};
          cnt_d = cnt_q + CNT_W'(1);
          // A carry out of the top digit cannot happen for clamped inputs;
          // folding it into overflow keeps the display honest if it ever did.
          ovf_conv_d = ovf_conv_q | bcd_adj[BCD_W-1];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Requests arriving mid-conversion park in the pending slot, newest wins
    if (score_valid && (state_q != IDLE)) begin
      pend_valid_d = 1'b1;
      pend_score_d = score_in;
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers, cleared asynchronously by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      busy_q         <= 1'b0;
      bin_q          <= '0;
      bcd_q          <= '0;
      cnt_q          <= '0;
      ovf_conv_q     <= 1'b0;
      digits_out_q   <= '0;
      overflow_q     <= 1'b0;
      digits_valid_q <= 1'b0;
      pend_valid_q   <= 1'b0;
      pend_score_q   <= '0;
    end else begin
      state_q        <= state_d;
      busy_q         <= busy_d;
      bin_q          <= bin_d;
      bcd_q          <= bcd_d;
      cnt_q          <= cnt_d;
      ovf_conv_q     <= ovf_conv_d;
      digits_out_q   <= digits_out_d;
      overflow_q     <= overflow_d;
      digits_valid_q <= digits_valid_d;
      pend_valid_q   <= pend_valid_d;
      pend_score_q   <= pend_score_d;
    end
  end

  assign busy         = busy_q;
  assign digits_out   = digits_out_q;
  assign digits_valid = digits_valid_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_score_bcd_converter.sv
// Scoreboard bench for score_bcd_converter: stimulus pushes expected results,
// a monitor pops and compares on every digits_valid pulse.
module tb_score_bcd_converter;

  logic        clk;
  logic        reset;
  logic [19:0] score_in;
  logic        score_valid;
  logic        busy;
  logic [23:0] digits_out;
  logic        digits_valid;
  logic        overflow;

  typedef struct packed {
    logic [23:0] digits;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   total  = 0;
  int   bad    = 0;
  int   pulses = 0;

  score_bcd_converter #(
    .SCORE_WIDTH (20),
    .DIGITS      (6)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .score_in     (score_in),
    .score_valid  (score_valid),
    .busy         (busy),
    .digits_out   (digits_out),
    .digits_valid (digits_valid),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic expect_result(input logic [23:0] d, input logic o);
    exp_t e;
    e.digits = d;
    e.ovf    = o;
    exp_q.push_back(e);
  endtask

  // Monitor: every digits_valid sample is compared against the scoreboard head
  always @(negedge clk) begin
    exp_t e;
    if (!reset && digits_valid) begin
      pulses++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got digits=%06h ovf=%0b want no pulse", digits_out, overflow);
      end else begin
        e = exp_q.pop_front();
        $display("txn digits=%06h ovf=%0b expected digits=%06h ovf=%0b", digits_out, overflow, e.digits, e.ovf);
        check("digits", 32'(digits_out), 32'(e.digits));
        check("overflow", 32'(overflow), 32'(e.ovf));
      end
    end
  end

  // One isolated conversion; measures latency and busy length from the bench side.
  // Valid is raised at negedge N0, so the load edge falls before N1; digits_valid
  // on the 21st edge after the load is first seen at N22, and busy spans N1..N22.
  task automatic run_conv(input logic [19:0] val, input logic [23:0] exp_d, input logic exp_o, input string tag);
    int cyc;
    int busy_cnt;
    bit seen;
    expect_result(exp_d, exp_o);
    @(negedge clk);
    score_in    = val;
    score_valid = 1'b1;
    cyc      = 0;
    busy_cnt = 0;
    seen     = 1'b0;
    while (cyc < 40 && !seen) begin
      @(negedge clk);
      score_valid = 1'b0;
      cyc++;
      if (busy) busy_cnt++;
      if (digits_valid) seen = 1'b1;
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'd22);
    @(negedge clk);
    if (busy) busy_cnt++;
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_single_pulse"}, 32'(digits_valid), 32'd0);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd22);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    int cyc;
    int pulses_before;

    reset       = 1'b1;
    score_valid = 1'b0;
    score_in    = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(digits_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_digits", 32'(digits_out), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    run_conv(20'd0,       24'h000000, 1'b0, "zero");
    run_conv(20'd123456,  24'h123456, 1'b0, "mid");
    run_conv(20'd999999,  24'h999999, 1'b0, "max");
    run_conv(20'd1048575, 24'h999999, 1'b1, "full_scale");
    run_conv(20'd1000000, 24'h999999, 1'b1, "max_plus_one");
    run_conv(20'd100000,  24'h100000, 1'b0, "ovf_clears");
    run_conv(20'd90,      24'h000090, 1'b0, "small");

    // 42 converts; 7 then 9 arrive while busy, 9 overwrites 7 in the pending slot
    pulses_before = pulses;
    expect_result(24'h000042, 1'b0);
    expect_result(24'h000009, 1'b0);
    @(negedge clk);
    score_in = 20'd42; score_valid = 1'b1;
    @(negedge clk);
    score_valid = 1'b0;
    repeat (3) @(negedge clk);
    score_in = 20'd7; score_valid = 1'b1;
    @(negedge clk);
    score_valid = 1'b0;
    repeat (4) @(negedge clk);
    score_in = 20'd9; score_valid = 1'b1;
    @(negedge clk);
    score_valid = 1'b0;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("pending_drained", 32'(exp_q.size()), 32'd0);
    repeat (10) @(negedge clk);
    check("pending_pulses", 32'(pulses - pulses_before), 32'd2);
    check("hold_digits", 32'(digits_out), 32'h000009);
    check("hold_busy", 32'(busy), 32'd0);

    // Leave nonzero outputs behind so the reset clear is visible
    run_conv(20'd1040000, 24'h999999, 1'b1, "pre_reset");

    // Reset after shift edge 10 of a 555555 conversion: no result may appear
    pulses_before = pulses;
    @(negedge clk);
    score_in = 20'd555555; score_valid = 1'b1;
    @(negedge clk);
    score_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("before_abort_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_digits", 32'(digits_out), 32'd0);
    check("abort_overflow", 32'(overflow), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(digits_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("abort_no_pulse", 32'(pulses - pulses_before), 32'd0);

    run_conv(20'd10, 24'h000010, 1'b0, "after_reset");

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/score_bcd_converter.md
SCORE_BCD_CONVERTER -- requirements
Module: score_bcd_converter

Interface
REQ-001 The block SHALL use parameter SCORE_WIDTH, default 20, as the width of the binary score input.
REQ-002 The block SHALL use parameter DIGITS, default 6, as the number of BCD digits produced, one per seven-segment display.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port score_in, input, SCORE_WIDTH bits: unsigned binary score from game logic.
REQ-006 The block SHALL have port score_valid, input, 1 bit: score_in is sampled on any rising edge where this is high.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-008 The block SHALL have port digits_out, output, 4*DIGITS bits: packed BCD, digit 0 (units) in bits [3:0].
REQ-009 The block SHALL have port digits_valid, output, 1 bit: one-cycle pulse when digits_out is updated.
REQ-010 The block SHALL have port overflow, output, 1 bit: high when the last converted score exceeded SCORE_MAX and was clamped.

Function
REQ-011 The block SHALL implement a sequential double-dabble converter with states IDLE, SHIFT and DONE.
REQ-012 In IDLE, with a request available, it SHALL load the shift register with min(score, SCORE_MAX), where SCORE_MAX = 10^DIGITS - 1 (999999).
- It SHALL clear the BCD accumulator and the shift counter, then go to SHIFT.
REQ-013 In SHIFT, each cycle it SHALL apply the add-3 correction to every BCD nibble >= 5, then shift {bcd, bin} left by one bit.
REQ-014 After exactly SCORE_WIDTH shifts it SHALL go to DONE.
- In DONE it SHALL register digits_out and overflow, pulse digits_valid for one cycle, then return to IDLE.
REQ-015 Latency SHALL be SCORE_WIDTH+1 rising edges (21 by default) from the edge that loads the score to the edge that raises digits_valid.
REQ-016 busy SHALL be high from the load edge until the edge that leaves DONE, and low in IDLE.
REQ-017 digits_out and overflow SHALL hold their last values between conversions.
REQ-018 A score_valid received while busy SHALL be stored in a one-deep pending register.
- A later score_valid while busy SHALL overwrite the pending value (newest wins).
- The block SHALL never drop the most recent request.
REQ-019 In IDLE, a simultaneous score_valid and pending request SHALL load score_in and clear pending.
- Otherwise a pending request SHALL be loaded on the first IDLE edge.
REQ-020 score_in values above SCORE_MAX SHALL convert to all-9 digits with overflow=1; values <= SCORE_MAX SHALL set overflow=0.
REQ-021 No arithmetic SHALL use division or modulo; the correction is a 4-bit compare-and-add per nibble.

Reset
REQ-022 On reset high the block SHALL go immediately to IDLE, asynchronously, and clear all state and outputs:
- busy=0, digits_valid=0, overflow=0
- digits_out=0 (displays read 000000)
- pending cleared
REQ-023 Reset asserted mid-conversion SHALL abort the conversion with no digits_valid pulse.
- The first request after reset release SHALL convert normally.

Structure
REQ-024 The shared package SHALL hold SCORE_WIDTH, DIGITS, SCORE_MAX and the IDLE/SHIFT/DONE state encoding, for use by game logic and the display path.
REQ-025 The block SHALL instantiate sub-module bcd_digit_adjust once per digit: a combinational 4-bit in/out add-3-if->=5 cell.
REQ-026 Seven-segment decoding SHALL remain downstream; this block outputs BCD only.

Verification
REQ-027 The bench SHALL cover these scenarios:
- score_in=0 with a score_valid pulse -> after 21 edges digits_out=0x000000, digits_valid pulses once, overflow=0.
- score_in=123456 -> digits_out=0x123456; busy high for exactly 22 cycles.
- score_in=999999 -> 0x999999 with overflow=0; then score_in=1048575 -> 0x999999 with overflow=1.
- score_in=42, then 7 and 9 while busy -> exactly two digits_valid pulses, with digits_out 0x000042 then 0x000009; 7 is never output.
- Reset asserted at shift cycle 10 of a 555555 conversion -> outputs 0 immediately, no digits_valid pulse; a new request for 10 -> 0x000010.
